pwm_duty_meter: RTL and testbench

Receive-side counterpart of the PWM generator: samples an incoming PWM waveform, measures its period and high time in clk cycles, and reports the duty cycle as an integer number of tenths (0..PERIOD_CYCLES). Sits behind an io_in pin in a tile-level top, with its outputs driving io_out. It can close a loopback test of the generator or read an external PWM source. Also flags malformed periods and detects static (0 % / 100 %) inputs.

---
 rtl/pwm_duty_meter_pkg.sv | 13 +
 rtl/pwm_edge_detect.sv | 24 ++
 rtl/pwm_duty_meter.sv | 150 +++++++++++++++
 tb/tb_pwm_duty_meter.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/pwm_duty_meter_pkg.sv
// Shared definitions for the PWM duty meter: default PWM period (shared with the generator)
// and the measurement FSM encoding.
package pwm_duty_meter_pkg;

    localparam int unsigned PwmPeriodCycles = 10;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StMeasure = 2'd1,
        StStatic  = 2'd2
    } meter_state_e;

endpackage

// File: rtl/pwm_edge_detect.sv
// Edge detector on the synchronized PWM level. prev_q resets high so that an input that is
// already high when reset releases is not mistaken for a rising edge.
module pwm_edge_detect (
    input  logic clk_i,
    input  logic rst_i,
    input  logic s_i,
    output logic rise_o,
    output logic fall_o
);

    logic prev_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            prev_q <= 1'b1;
        end else begin
            prev_q <= s_i;
        end
    end

    assign rise_o = s_i & ~prev_q;
    assign fall_o = ~s_i & prev_q;

endmodule

// File: rtl/pwm_duty_meter.sv
// Measures period and high time of an asynchronous PWM input in clk cycles, reports the duty
// in cycles, flags periods of the wrong length and detects static 0 %/100 % inputs.
module pwm_duty_meter
    import pwm_duty_meter_pkg::*;
#(
    parameter int unsigned PERIOD_CYCLES = PwmPeriodCycles,
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned DUTY_W        = $clog2(PERIOD_CYCLES + 1),
    parameter int unsigned CNT_W         = $clog2(2 * PERIOD_CYCLES + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pwm_in,
    output logic [DUTY_W-1:0] duty_out,
    output logic              duty_valid,
    output logic              locked,
    output logic              period_err
);

    localparam logic [CNT_W-1:0]  PeriodCnt = CNT_W'(PERIOD_CYCLES);
    localparam logic [CNT_W-1:0]  SatCnt    = CNT_W'(2 * PERIOD_CYCLES);
    localparam logic [CNT_W-1:0]  OneCnt    = CNT_W'(1);
    localparam logic [DUTY_W-1:0] FullDuty  = DUTY_W'(PERIOD_CYCLES);

    // Synchronizer chain, deliberately without reset.
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;

    always_ff @(posedge clk) begin
        sync_q[0] <= pwm_in;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_q[i] <= sync_q[i-1];
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    logic rise;
    logic fall;

    pwm_edge_detect u_edge_detect (
        .clk_i  (clk),
        .rst_i  (rst),
        .s_i    (s),
        .rise_o (rise),
        .fall_o (fall)
    );

    meter_state_e      state_q, state_d;
    logic [CNT_W-1:0]  period_cnt_q, period_cnt_d;
    logic [CNT_W-1:0]  high_cnt_q, high_cnt_d;
    logic [DUTY_W-1:0] duty_q, duty_d;
    logic              valid_q, valid_d;
    logic              locked_q, locked_d;
    logic              perr_q, perr_d;

    always_comb begin
        period_cnt_d = period_cnt_q;
        high_cnt_d   = high_cnt_q;
        if (rise) begin
            period_cnt_d = OneCnt;
            high_cnt_d   = OneCnt;
        end else if (state_q == StStatic && fall) begin
            period_cnt_d = '0;
            high_cnt_d   = '0;
        end else begin
            if (period_cnt_q != SatCnt) begin
                period_cnt_d = period_cnt_q + 1'b1;
            end
            if (s && high_cnt_q != SatCnt) begin
                high_cnt_d = high_cnt_q + 1'b1;
            end
        end
    end

    // Rise is checked before saturation everywhere so a coincident edge wins.
    always_comb begin
        state_d  = state_q;
        duty_d   = duty_q;
        valid_d  = 1'b0;
        locked_d = locked_q;
        perr_d   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (rise) begin
                    state_d = StMeasure;
                end else if (period_cnt_q == SatCnt) begin
                    state_d  = StStatic;
                    duty_d   = s ? FullDuty : '0;
                    valid_d  = 1'b1;
                    locked_d = 1'b1;
                end
            end
            StMeasure: begin
                if (rise) begin
                    if (period_cnt_q == PeriodCnt) begin
                        duty_d   = high_cnt_q[DUTY_W-1:0];
                        valid_d  = 1'b1;
                        locked_d = 1'b1;
                    end else begin
                        perr_d   = 1'b1;
                        locked_d = 1'b0;
                    end
                end else if (period_cnt_q == SatCnt) begin
                    state_d  = StStatic;
                    duty_d   = s ? FullDuty : '0;
                    valid_d  = 1'b1;
                    locked_d = 1'b1;
                end
            end
            StStatic: begin
                if (rise) begin
                    state_d = StMeasure;
                end else if (fall) begin
                    duty_d  = '0;
                    valid_d = 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            period_cnt_q <= '0;
            high_cnt_q   <= '0;
            duty_q       <= '0;
            valid_q      <= 1'b0;
            locked_q     <= 1'b0;
            perr_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            period_cnt_q <= period_cnt_d;
            high_cnt_q   <= high_cnt_d;
            duty_q       <= duty_d;
            valid_q      <= valid_d;
            locked_q     <= locked_d;
            perr_q       <= perr_d;
        end
    end

    assign duty_out   = duty_q;
    assign duty_valid = valid_q;
    assign locked     = locked_q;
    assign period_err = perr_q;

endmodule

// File: tb/tb_pwm_duty_meter.sv
// Directed bench for pwm_duty_meter: hand-computed duties, static detection timing, bad period,
// reset mid-period and a loopback from a small behavioural PWM generator.
module tb_pwm_duty_meter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pwm_drv = 1'b0;
    logic       loop_en = 1'b0;
    logic       pwm_in;
    logic [3:0] duty_out;
    logic       duty_valid;
    logic       locked;
    logic       period_err;

    int passed = 0;
    int total = 0;
    int valid_cnt = 0;
    int perr_cnt = 0;
    int both_cnt = 0;

    // Behavioural generator: 10-cycle period, duty bumps by one at the next period boundary
    logic [3:0] gen_cnt = 4'd0;
    logic [3:0] gen_duty = 4'd5;
    logic       gen_pend = 1'b0;
    logic       gen_inc = 1'b0;
    logic       gen_out;

    always #5 clk = ~clk;

    assign gen_out = (gen_cnt < gen_duty);
    assign pwm_in  = loop_en ? gen_out : pwm_drv;

    always @(posedge clk) begin
        gen_cnt <= (gen_cnt == 4'd9) ? 4'd0 : gen_cnt + 4'd1;
        if (gen_inc) begin
            gen_pend <= 1'b1;
        end else if (gen_cnt == 4'd9 && gen_pend) begin
            gen_duty <= gen_duty + 4'd1;
            gen_pend <= 1'b0;
        end
    end

    always @(negedge clk) begin
        if (duty_valid) valid_cnt++;
        if (period_err) perr_cnt++;
        if (duty_valid && period_err) both_cnt++;
    end

    pwm_duty_meter dut (
        .clk        (clk),
        .rst        (rst),
        .pwm_in     (pwm_in),
        .duty_out   (duty_out),
        .duty_valid (duty_valid),
        .locked     (locked),
        .period_err (period_err)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic level, input int n);
        pwm_drv = level;
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic run_period(input int high, input int len);
        drive(1'b1, high);
        drive(1'b0, len - high);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    initial begin
        // Reset with pwm_in low, then static-low detection from reset
        rst = 1'b1;
        drive(1'b0, 3);
        check("rst_duty", 32'(duty_out), 0);
        check("rst_valid", 32'(duty_valid), 0);
        check("rst_locked", 32'(locked), 0);
        check("rst_perr", 32'(period_err), 0);
        rst = 1'b0;
        drive(1'b0, 20);
        check("stlow_none_before", 32'(valid_cnt), 0);
        drive(1'b0, 1);
        check("stlow_valid", 32'(duty_valid), 1);
        check("stlow_duty", 32'(duty_out), 0);
        check("stlow_locked", 32'(locked), 1);
        drive(1'b0, 1);
        check("stlow_pulse_width", 32'(duty_valid), 0);
        valid_cnt = 0;
        perr_cnt  = 0;

        // 50 % duty: rises 2..4 each report a good period
        for (int p = 0; p < 4; p++) run_period(5, 10);
        check("d50_valid_cnt", 32'(valid_cnt), 3);
        check("d50_duty", 32'(duty_out), 5);
        check("d50_locked", 32'(locked), 1);
        check("d50_no_perr", 32'(perr_cnt), 0);

        // Boundary duties
        for (int p = 0; p < 3; p++) run_period(1, 10);
        check("d10_duty", 32'(duty_out), 1);
        for (int p = 0; p < 3; p++) run_period(9, 10);
        check("d90_duty", 32'(duty_out), 9);
        check("d90_locked", 32'(locked), 1);

        // Lock at 3, then hold high: static after 20 cycles from the detected rise
        for (int p = 0; p < 3; p++) run_period(3, 10);
        drive(1'b1, 3);
        check("sthi_last_valid", 32'(duty_valid), 1);
        check("sthi_last_duty", 32'(duty_out), 3);
        drive(1'b1, 19);
        check("sthi_not_yet", 32'(duty_valid), 0);
        check("sthi_duty_hold", 32'(duty_out), 3);
        drive(1'b1, 1);
        check("sthi_valid", 32'(duty_valid), 1);
        check("sthi_duty", 32'(duty_out), 10);
        check("sthi_locked", 32'(locked), 1);
        drive(1'b1, 1);
        valid_cnt = 0;
        drive(1'b1, 30);
        check("sthi_no_repeat", 32'(valid_cnt), 0);

        // Falling edge while static
        drive(1'b0, 2);
        check("stfall_not_yet", 32'(duty_valid), 0);
        drive(1'b0, 1);
        check("stfall_valid", 32'(duty_valid), 1);
        check("stfall_duty", 32'(duty_out), 0);
        drive(1'b0, 7);

        // Bad 12-cycle period between good 4/10 periods
        for (int p = 0; p < 3; p++) run_period(4, 10);
        check("bad_pre_duty", 32'(duty_out), 4);
        perr_cnt  = 0;
        both_cnt  = 0;
        run_period(4, 12);
        drive(1'b1, 3);
        check("bad_perr", 32'(period_err), 1);
        check("bad_no_valid", 32'(duty_valid), 0);
        check("bad_unlocked", 32'(locked), 0);
        check("bad_duty_hold", 32'(duty_out), 4);
        drive(1'b1, 1);
        check("bad_perr_width", 32'(period_err), 0);
        drive(1'b0, 6);
        drive(1'b1, 3);
        check("bad_recover_valid", 32'(duty_valid), 1);
        check("bad_recover_duty", 32'(duty_out), 4);
        check("bad_recover_locked", 32'(locked), 1);
        drive(1'b1, 1);
        drive(1'b0, 6);
        check("bad_one_perr", 32'(perr_cnt), 1);

        // Reset mid-high
        drive(1'b1, 3);
        rst = 1'b1;
        drive(1'b1, 3);
        check("mrst_duty", 32'(duty_out), 0);
        check("mrst_valid", 32'(duty_valid), 0);
        check("mrst_locked", 32'(locked), 0);
        check("mrst_perr", 32'(period_err), 0);
        rst = 1'b0;
        drive(1'b1, 2);
        check("mrst_no_rise", 32'(duty_valid), 0);
        drive(1'b0, 5);
        valid_cnt = 0;
        run_period(6, 10);
        check("mrst_first_rise_silent", 32'(valid_cnt), 0);
        drive(1'b1, 3);
        check("mrst_second_valid", 32'(duty_valid), 1);
        check("mrst_second_duty", 32'(duty_out), 6);
        check("mrst_second_locked", 32'(locked), 1);
        drive(1'b1, 3);
        drive(1'b0, 4);

        // Loopback from the generator, duty 5 -> 6 -> 7
        loop_en = 1'b1;
        for (int i = 0; i < 40; i++) step();
        check("loop_duty5", 32'(duty_out), 5);
        check("loop_locked5", 32'(locked), 1);
        perr_cnt = 0;
        gen_inc  = 1'b1;
        step();
        gen_inc  = 1'b0;
        for (int i = 0; i < 40; i++) step();
        check("loop_duty6", 32'(duty_out), 6);
        gen_inc  = 1'b1;
        step();
        gen_inc  = 1'b0;
        for (int i = 0; i < 40; i++) step();
        check("loop_duty7", 32'(duty_out), 7);
        check("loop_locked7", 32'(locked), 1);
        check("loop_no_perr", 32'(perr_cnt), 0);
        check("never_both_pulses", 32'(both_cnt), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
